// File: rtl/multicycle_alu.sv
// multicycle_alu: execute-stage ALU behind a start/done handshake.
// Logic, arithmetic and compare ops finish in one cycle. Shifts move one bit
// per cycle through a working register, so no barrel shifter is needed.
module multicycle_alu #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [3:0]         alu_operation,
   input  logic [WIDTH-1:0]   operand_a,
   input  logic [WIDTH-1:0]   operand_b,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result,
   output logic               zero
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_U_LOW_EQ, OP_S_LOW_EQ, OP_U_HIGH_EQ, OP_S_HIGH_EQ,
      OP_U_LOWER, OP_S_LOWER, OP_U_HIGHER, OP_S_HIGHER,
      OP_SLL, OP_SRL, OP_SRA
   } alu_op_t;

   typedef enum logic [1:0] {SH_LEFT, SH_RLOG, SH_RARI} shift_t;

   state_t               state_q, state_d;
   logic [SHAMT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]     work_q, work_d;
   shift_t               kind_q, kind_d;
   logic                 fill_q, fill_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 zero_q, zero_d;

   logic [WIDTH-1:0]     alu_res;
   logic [WIDTH-1:0]     shifted;
   logic [SHAMT_W-1:0]   shamt;
   logic                 is_shift;
   logic                 cmp;

   assign shamt    = operand_b[SHAMT_W-1:0];
   assign is_shift = (alu_operation[3:2] == 2'b11) && (alu_operation[1:0] != 2'b00);

   // Single-cycle result from the live inputs (shift opcodes handled by the FSM)
   always_comb begin
      alu_res = '0;
      cmp     = 1'b0;
      case (alu_op_t'(alu_operation))
         OP_ADD:       alu_res = operand_a + operand_b;
         OP_SUB:       alu_res = operand_a - operand_b;
         OP_AND:       alu_res = operand_a & operand_b;
         OP_OR:        alu_res = operand_a | operand_b;
         OP_XOR:       alu_res = operand_a ^ operand_b;
         OP_U_LOW_EQ:  cmp = operand_a <= operand_b;
         OP_S_LOW_EQ:  cmp = $signed(operand_a) <= $signed(operand_b);
         OP_U_HIGH_EQ: cmp = operand_a >= operand_b;
         OP_S_HIGH_EQ: cmp = $signed(operand_a) >= $signed(operand_b);
         OP_U_LOWER:   cmp = operand_a < operand_b;
         OP_S_LOWER:   cmp = $signed(operand_a) < $signed(operand_b);
         OP_U_HIGHER:  cmp = operand_a > operand_b;
         OP_S_HIGHER:  cmp = $signed(operand_a) > $signed(operand_b);
         default:      alu_res = '0;
      endcase
      if (alu_operation >= 4'd5 && alu_operation <= 4'd12)
         alu_res = {{(WIDTH-1){1'b0}}, cmp};
   end

   // One-bit step of the working register; arithmetic fill uses the captured sign
   always_comb begin
      shifted = work_q;
      case (kind_q)
         SH_LEFT: shifted = {work_q[WIDTH-2:0], 1'b0};
         SH_RLOG: shifted = {1'b0, work_q[WIDTH-1:1]};
         SH_RARI: shifted = {fill_q, work_q[WIDTH-1:1]};
         default: shifted = work_q;
      endcase
   end

   // Next-state and datapath updates for IDLE/SHIFT/DONE
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      work_d   = work_q;
      kind_d   = kind_q;
      fill_d   = fill_q;
      result_d = result_q;
      zero_d   = zero_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (!is_shift) begin
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  state_d  = DONE;
               end else if (shamt == '0) begin
                  result_d = operand_a;
                  zero_d   = (operand_a == '0);
                  state_d  = DONE;
               end else begin
                  work_d  = operand_a;
                  cnt_d   = shamt;
                  fill_d  = operand_a[WIDTH-1];
                  kind_d  = (alu_operation[1:0] == 2'b01) ? SH_LEFT :
                            (alu_operation[1:0] == 2'b10) ? SH_RLOG : SH_RARI;
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            work_d = shifted;
            cnt_d  = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               result_d = shifted;
               zero_d   = (shifted == '0);
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         work_q   <= '0;
         kind_q   <= SH_LEFT;
         fill_q   <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         work_q   <= work_d;
         kind_q   <= kind_d;
         fill_q   <= fill_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign result = result_q;
   assign zero   = zero_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed and randomized checks of multicycle_alu against a behavioural model.
module tb_multicycle_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  alu_operation;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        zero;

   int checks = 0;
   int errors = 0;

   multicycle_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .alu_operation (alu_operation),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .busy          (busy),
      .done          (done),
      .result        (result),
      .zero          (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return (a <= b) ? 32'd1 : 32'd0;
         4'd6:  return ($signed(a) <= $signed(b)) ? 32'd1 : 32'd0;
         4'd7:  return (a >= b) ? 32'd1 : 32'd0;
         4'd8:  return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
         4'd9:  return (a < b) ? 32'd1 : 32'd0;
         4'd10: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd11: return (a > b) ? 32'd1 : 32'd0;
         4'd12: return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
         4'd13: return a << sh;
         4'd14: return a >> sh;
         default: return $unsigned($signed(a) >>> sh);
      endcase
   endfunction

   // Issue one op, scramble inputs after accept, wait for done within a bound.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit pulse, input string tag);
      logic [31:0] exp;
      int exp_lat;
      int lat;
      bit seen;
      exp     = ref_res(op, a, b);
      exp_lat = (op >= 4'd13 && b[4:0] != 5'd0) ? int'(b[4:0]) + 1 : 1;
      @(negedge clk);
      start = 1'b1; alu_operation = op; operand_a = a; operand_b = b;
      @(posedge clk); #1;
      start = 1'b0;
      operand_a = $urandom; operand_b = $urandom; alu_operation = 4'($urandom);
      lat  = 1;
      seen = 1'b0;
      while (lat <= 40) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         check({tag, " busy"}, 32'(busy), 32'd1);
         if (pulse && lat == 2) begin
            start = 1'b1; alu_operation = 4'd0; operand_a = 32'd100; operand_b = 32'd1;
         end
         if (pulse && lat == 3) start = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " done seen"}, 32'(seen), 32'd1);
      if (seen) begin
         check({tag, " latency"}, 32'(lat), 32'(exp_lat));
         check({tag, " result"}, result, exp);
         check({tag, " zero"}, 32'(zero), (exp == 32'd0) ? 32'd1 : 32'd0);
         check({tag, " busy@done"}, 32'(busy), 32'd1);
      end
      @(posedge clk); #1;
      check({tag, " done drop"}, 32'(done), 32'd0);
      check({tag, " idle"}, 32'(busy), 32'd0);
      check({tag, " result hold"}, result, exp);
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] a, b;
      int          dones;

      rst = 1'b1; start = 1'b0; alu_operation = '0; operand_a = '0; operand_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      check("reset result", result, 32'd0);
      check("reset zero", 32'(zero), 32'd1);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);

      run_op(4'd0,  32'hFFFF_FFFF, 32'd1,         1'b0, "add wrap");
      run_op(4'd1,  32'd5,         32'd7,         1'b0, "sub");
      run_op(4'd10, 32'hFFFF_FFFF, 32'd1,         1'b0, "s_lower");
      run_op(4'd9,  32'hFFFF_FFFF, 32'd1,         1'b0, "u_lower");
      run_op(4'd7,  32'h8000_0000, 32'h8000_0000, 1'b0, "u_high_eq");
      run_op(4'd15, 32'h8000_0000, 32'h0000_001F, 1'b0, "sra 31");
      run_op(4'd14, 32'h8000_0000, 32'h0000_001F, 1'b0, "srl 31");
      run_op(4'd13, 32'h1,         32'hFFFF_FFE0, 1'b0, "sll 0");
      run_op(4'd13, 32'h1,         32'd4,         1'b0, "sll 4");
      run_op(4'd14, 32'hF0F0_1234, 32'd8,         1'b1, "srl 8 start pulse");

      // Abort a 10-bit shift with reset on its third cycle
      @(negedge clk);
      start = 1'b1; alu_operation = 4'd13; operand_a = 32'h0000_0003; operand_b = 32'd10;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("abort result", result, 32'd0);
      check("abort zero", 32'(zero), 32'd1);
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      @(negedge clk); rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      check("abort no done", 32'(dones), 32'd0);
      run_op(4'd0, 32'd2, 32'd3, 1'b0, "add after abort");

      for (int n = 0; n < 50; n++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) b = a;
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         if ($urandom_range(0, 7) == 0) b = 32'h7FFF_FFFF;
         run_op(op, a, b, 1'b0, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
